// File: rtl/button_conditioner_if.sv
// Pushbutton event bus: raw active-low keys in, debounced level and
// one-cycle press/release pulses out.
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    input  btn,
    output btn_level,
    output btn_press,
    output btn_release
  );

  modport slave (
    output btn,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel synchroniser, debouncer and edge-pulse generator for the
// active-low board keys; channels are fully independent.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.master bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_e;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  state_e           state_q [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];

  // Two-flop synchroniser; resets to the released (high) key level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {N_BTN{1'b1}};
      sync2_q <= {N_BTN{1'b1}};
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSMs with registered level and pulse outputs; pulses self-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= {N_BTN{1'b0}};
      press_q   <= {N_BTN{1'b0}};
      release_q <= {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
        case (state_q[i])
          RELEASED: begin
            if (!sync2_q[i]) begin
              state_q[i] <= PRESS_PEND;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          PRESS_PEND: begin
            if (sync2_q[i]) begin
              state_q[i] <= RELEASED;
              cnt_q[i]   <= CNT_ZERO;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= PRESSED;
              cnt_q[i]   <= CNT_ZERO;
              press_q[i] <= 1'b1;
              level_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          PRESSED: begin
            if (sync2_q[i]) begin
              state_q[i] <= RELEASE_PEND;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          RELEASE_PEND: begin
            // An opposite sample falls straight back; the count restarts on the next change.
            if (!sync2_q[i]) begin
              state_q[i] <= PRESSED;
              cnt_q[i]   <= CNT_ZERO;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i]   <= RELEASED;
              cnt_q[i]     <= CNT_ZERO;
              release_q[i] <= 1'b1;
              level_q[i]   <= 1'b0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= RELEASED;
            cnt_q[i]   <= CNT_ZERO;
            level_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4: stimulus
// queues expected pulses, a negedge monitor pops and compares them.
module tb_button_conditioner;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int LAT = DEB + 2;

  typedef struct {
    int ch;
    bit rel;
    int cyc;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  int         cyc;
  int         checks;
  int         errors;
  ev_t        exp_q[$];

  button_conditioner_if #(.N_BTN(N)) bus ();

  assign bus.btn = btn;

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int ch, input bit rel, input int at);
    ev_t e;
    e.ch  = ch;
    e.rel = rel;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse the DUT shows must match the next queued event.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < N; c++) begin
        for (int r = 0; r < 2; r++) begin
          if ((r == 0) ? bus.btn_press[c] : bus.btn_release[c]) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_pulse: ch %0d rel %0d at cycle %0d, expected none", c, r, cyc);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.ch != c || e.rel != r[0] || e.cyc != cyc) begin
                errors++;
                $display("FAIL pulse: got ch %0d rel %0d cycle %0d, expected ch %0d rel %0d cycle %0d",
                         c, r, cyc, e.ch, e.rel, e.cyc);
              end
            end
            checks++;
            if (bus.btn_level[c] !== (r == 0)) begin
              errors++;
              $display("FAIL level_with_pulse: ch %0d got %0b, expected %0b", c, bus.btn_level[c], (r == 0));
            end
          end
        end
      end
    end
  end

  initial begin
    int k;
    int r;
    checks = 0;
    errors = 0;
    cyc    = 0;
    btn    = 4'b1111;
    rst_n  = 1'b0;
    wait_neg(3);
    check("reset_level", {28'd0, bus.btn_level}, 32'd0);
    check("reset_press", {28'd0, bus.btn_press}, 32'd0);
    check("reset_release", {28'd0, bus.btn_release}, 32'd0);
    rst_n = 1'b1;
    wait_neg(3);

    // 1: clean press on btn[0], held 20 cycles, then released
    btn[0] = 1'b0; k = cyc; expect_ev(0, 1'b0, k + LAT);
    wait_neg(20);
    check("t1_level_held", {31'd0, bus.btn_level[0]}, 32'd1);
    btn[0] = 1'b1; k = cyc; expect_ev(0, 1'b1, k + LAT);
    wait_neg(12);
    check("t1_level_after_release", {31'd0, bus.btn_level[0]}, 32'd0);

    // 2: three-cycle glitch on btn[1] is rejected
    btn[1] = 1'b0;
    wait_neg(3);
    btn[1] = 1'b1;
    wait_neg(12);
    check("t2_level_glitch", {31'd0, bus.btn_level[1]}, 32'd0);

    // 3: btn[2] press, then release with bounces 1,1,0,0 before staying high
    btn[2] = 1'b0; k = cyc; expect_ev(2, 1'b0, k + LAT);
    wait_neg(12);
    btn[2] = 1'b1; wait_neg(2);
    btn[2] = 1'b0; wait_neg(2);
    check("t3_level_during_bounce", {31'd0, bus.btn_level[2]}, 32'd1);
    btn[2] = 1'b1; k = cyc; expect_ev(2, 1'b1, k + LAT);
    wait_neg(12);
    check("t3_level_final", {31'd0, bus.btn_level[2]}, 32'd0);

    // 4: all four pressed on the same edge, then all released
    btn = 4'b0000; k = cyc;
    for (int c = 0; c < N; c++) expect_ev(c, 1'b0, k + LAT);
    wait_neg(12);
    check("t4_level_all", {28'd0, bus.btn_level}, 32'hF);
    btn = 4'b1111; k = cyc;
    for (int c = 0; c < N; c++) expect_ev(c, 1'b1, k + LAT);
    wait_neg(12);

    // 5: async reset while btn[0] is pending with btn[3] held
    btn[3] = 1'b0; k = cyc; expect_ev(3, 1'b0, k + LAT);
    wait_neg(12);
    btn[0] = 1'b0;
    wait_neg(4);
    rst_n = 1'b0;
    #1;
    check("t5_async_level", {28'd0, bus.btn_level}, 32'd0);
    check("t5_async_press", {28'd0, bus.btn_press}, 32'd0);
    check("t5_async_release", {28'd0, bus.btn_release}, 32'd0);
    wait_neg(3);
    rst_n = 1'b1; r = cyc;
    expect_ev(0, 1'b0, r + LAT);
    expect_ev(3, 1'b0, r + LAT);
    wait_neg(12);
    check("t5_level_after_restart", {28'd0, bus.btn_level}, 32'h9);
    btn = 4'b1111; k = cyc;
    expect_ev(0, 1'b1, k + LAT);
    expect_ev(3, 1'b1, k + LAT);
    wait_neg(12);

    // 6: long hold on btn[2] yields one press and one release
    btn[2] = 1'b0; k = cyc; expect_ev(2, 1'b0, k + LAT);
    wait_neg(1000);
    check("t6_level_long_hold", {31'd0, bus.btn_level[2]}, 32'd1);
    btn[2] = 1'b1; k = cyc; expect_ev(2, 1'b1, k + LAT);
    wait_neg(20);

    check("all_events_seen", exp_q.size(), 32'd0);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      $display("FAIL missing_pulse: ch %0d rel %0d expected at cycle %0d, got none", e.ch, e.rel, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
